// File: rtl/alu_controller.sv
// ---------------------------------------------------------------------------------------------
// alu_controller
//
// Purpose:
//   Translates RISC-V funct7/funct3 and the main-control qualifiers into a 4-bit ALU operation
//   code and an operand-negate request. It sits between the main control decoder and the ALU.
//   Both outputs are registered, so a change at the inputs appears after the next rising edge.
//
// Ports:
//   clock            in   1     system clock, rising-edge active
//   reset            in   1     synchronous, active-high reset (ALUOp=ADD, negate=0)
//   Funct7           in   7     instruction bits [31:25]
//   Funct3           in   3     instruction bits [14:12]
//   MemRead          in   1     load instruction
//   MemWrite         in   1     store instruction
//   MemToReg         in   1     writeback-from-memory select
//   ALUSrc           in   2     00 reg/reg, 01 reg/imm, 10 PC+imm (AUIPC), 11 imm pass (LUI)
//   ALUOp            out  OP_W  registered ALU operation code
//   ALUControlNegate out  1     registered compare request (inverted B plus carry-in)
//   IllegalOp        out  1     registered illegal R-type flag (only with the macro below)
//
// Configuration:
//   ALU_CTRL_ILLEGAL_DET_EN  when defined, adds the IllegalOp output port.
// ---------------------------------------------------------------------------------------------
module alu_controller #(
    parameter int unsigned OP_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            MemToReg,
    input  logic [1:0]      ALUSrc,
    output logic [OP_W-1:0] ALUOp,
    output logic            ALUControlNegate
`ifdef ALU_CTRL_ILLEGAL_DET_EN
    ,
    output logic            IllegalOp
`endif
);

    // ALU operation encoding; 1011-1111 are never produced.
    localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLL   = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRL   = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
    localparam logic [OP_W-1:0] OP_SRA   = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLTU  = 4'b1001;
    localparam logic [OP_W-1:0] OP_PASSB = 4'b1010;

    // Operand classes carried on ALUSrc.
    localparam logic [1:0] SRC_RR    = 2'b00;
    localparam logic [1:0] SRC_RI    = 2'b01;
    localparam logic [1:0] SRC_AUIPC = 2'b10;
    localparam logic [1:0] SRC_LUI   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic            w_mem_access;
    logic            w_f7_base;
    logic            w_f7_alt;
    logic [OP_W-1:0] w_op_rr;
    logic            w_illegal_rr;
    logic [OP_W-1:0] w_op_ri;
    logic [OP_W-1:0] w_op;
    logic            w_negate;
    logic            w_illegal;

    logic [OP_W-1:0] r_alu_op;
    logic            r_negate;
    logic            r_illegal;

    assign w_mem_access = MemRead | MemWrite | MemToReg;
    assign w_f7_base    = (Funct7 == F7_BASE);
    assign w_f7_alt     = (Funct7 == F7_ALT);

    // R-type decode. Any funct7 other than the base/alt patterns (including the M extension's
    // 0000001) and any alt pattern outside ADD/SUB and SRL/SRA falls back to ADD and is flagged.
    always_comb begin
        w_op_rr      = OP_ADD;
        w_illegal_rr = 1'b0;
        if (w_f7_base) begin
            case (Funct3)
                3'b000:  w_op_rr = OP_ADD;
                3'b001:  w_op_rr = OP_SLL;
                3'b010:  w_op_rr = OP_SLT;
                3'b011:  w_op_rr = OP_SLTU;
                3'b100:  w_op_rr = OP_XOR;
                3'b101:  w_op_rr = OP_SRL;
                3'b110:  w_op_rr = OP_OR;
                default: w_op_rr = OP_AND;
            endcase
        end else if (w_f7_alt && (Funct3 == 3'b000)) begin
            w_op_rr = OP_SUB;
        end else if (w_f7_alt && (Funct3 == 3'b101)) begin
            w_op_rr = OP_SRA;
        end else begin
            w_op_rr      = OP_ADD;
            w_illegal_rr = 1'b1;
        end
    end

    // I-type decode. There is no SUBI, so funct7 only matters for the shift-right variant,
    // where bit 30 of the instruction (Funct7[5]) picks arithmetic over logical.
    always_comb begin
        w_op_ri = OP_ADD;
        case (Funct3)
            3'b000:  w_op_ri = OP_ADD;
            3'b001:  w_op_ri = OP_SLL;
            3'b010:  w_op_ri = OP_SLT;
            3'b011:  w_op_ri = OP_SLTU;
            3'b100:  w_op_ri = OP_XOR;
            3'b101:  w_op_ri = Funct7[5] ? OP_SRA : OP_SRL;
            3'b110:  w_op_ri = OP_OR;
            default: w_op_ri = OP_AND;
        endcase
    end

    // Priority: memory access address add, then AUIPC, LUI, R-type, I-type.
    always_comb begin
        w_op      = OP_ADD;
        w_illegal = 1'b0;
        if (w_mem_access) begin
            w_op = OP_ADD;
        end else begin
            case (ALUSrc)
                SRC_AUIPC: w_op = OP_ADD;
                SRC_LUI:   w_op = OP_PASSB;
                SRC_RR: begin
                    w_op      = w_op_rr;
                    w_illegal = w_illegal_rr;
                end
                SRC_RI:    w_op = w_op_ri;
                default:   w_op = OP_ADD;
            endcase
        end
    end

    // Only the compares use the inverted-B/carry-in path; SUB carries subtraction in its own code.
    assign w_negate = (w_op == OP_SLT) || (w_op == OP_SLTU);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_alu_op  <= OP_ADD;
            r_negate  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_alu_op  <= w_op;
            r_negate  <= w_negate;
            r_illegal <= w_illegal;
        end
    end

    assign ALUOp            = r_alu_op;
    assign ALUControlNegate = r_negate;

`ifdef ALU_CTRL_ILLEGAL_DET_EN
    assign IllegalOp = r_illegal;
`else
    // Flag register is still computed so both builds share one decode; it simply has no consumer.
    logic w_illegal_unused;
    assign w_illegal_unused = r_illegal;
`endif

endmodule

// File: tb/tb_alu_controller.sv
// ---------------------------------------------------------------------------------------------
// tb_alu_controller
//
// Self-checking bench for alu_controller: directed cases followed by randomized vectors, all
// compared against a table-driven reference model. Define ALU_CTRL_ILLEGAL_DET_EN to also
// check IllegalOp.
// ---------------------------------------------------------------------------------------------
module tb_alu_controller;

    logic       clock;
    logic       reset;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic [1:0] ALUSrc;
    logic [3:0] ALUOp;
    logic       ALUControlNegate;
`ifdef ALU_CTRL_ILLEGAL_DET_EN
    logic       IllegalOp;
`endif

    int n_vec;
    int n_err;

    // Reference encodings.
    localparam logic [3:0] AND_C   = 4'd0;
    localparam logic [3:0] OR_C    = 4'd1;
    localparam logic [3:0] ADD_C   = 4'd2;
    localparam logic [3:0] XOR_C   = 4'd3;
    localparam logic [3:0] SLL_C   = 4'd4;
    localparam logic [3:0] SRL_C   = 4'd5;
    localparam logic [3:0] SUB_C   = 4'd6;
    localparam logic [3:0] SLT_C   = 4'd7;
    localparam logic [3:0] SRA_C   = 4'd8;
    localparam logic [3:0] SLTU_C  = 4'd9;
    localparam logic [3:0] PASSB_C = 4'd10;

    logic [3:0] base_tbl [8];

    alu_controller #(
        .OP_W(4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .Funct7           (Funct7),
        .Funct3           (Funct3),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .MemToReg         (MemToReg),
        .ALUSrc           (ALUSrc),
        .ALUOp            (ALUOp),
        .ALUControlNegate (ALUControlNegate)
`ifdef ALU_CTRL_ILLEGAL_DET_EN
        ,
        .IllegalOp        (IllegalOp)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: decode from the rules directly, using a funct3 lookup table.
    task automatic model(input logic rst, input logic [6:0] f7, input logic [2:0] f3,
                         input logic mr, input logic mw, input logic mtr, input logic [1:0] src,
                         output logic [3:0] op, output logic neg, output logic ill);
        op  = ADD_C;
        ill = 1'b0;
        if (rst) begin
            op = ADD_C;
        end else if (mr || mw || mtr) begin
            op = ADD_C;
        end else if (src == 2'd2) begin
            op = ADD_C;
        end else if (src == 2'd3) begin
            op = PASSB_C;
        end else if (src == 2'd0) begin
            if (f7 == 7'h00) op = base_tbl[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) op = SUB_C;
            else if (f7 == 7'h20 && f3 == 3'd5) op = SRA_C;
            else begin
                op  = ADD_C;
                ill = 1'b1;
            end
        end else begin
            if (f3 == 3'd5 && f7[5]) op = SRA_C;
            else op = base_tbl[f3];
        end
        neg = (op == SLT_C) || (op == SLTU_C);
    endtask

    // Drive one input set on the falling edge, let one rising edge register it, then compare.
    task automatic apply(input string tag, input logic rst, input logic [6:0] f7,
                         input logic [2:0] f3, input logic mr, input logic mw, input logic mtr,
                         input logic [1:0] src);
        logic [3:0] e_op;
        logic       e_neg;
        logic       e_ill;
        @(negedge clock);
        reset    = rst;
        Funct7   = f7;
        Funct3   = f3;
        MemRead  = mr;
        MemWrite = mw;
        MemToReg = mtr;
        ALUSrc   = src;
        model(rst, f7, f3, mr, mw, mtr, src, e_op, e_neg, e_ill);
        @(posedge clock);
        #1;
        check({tag, ".op"}, 32'(ALUOp), 32'(e_op));
        check({tag, ".neg"}, 32'(ALUControlNegate), 32'(e_neg));
`ifdef ALU_CTRL_ILLEGAL_DET_EN
        check({tag, ".ill"}, 32'(IllegalOp), 32'(e_ill));
`endif
    endtask

    initial begin
        logic [6:0] f7;
        logic [2:0] f3;
        logic [1:0] src;
        logic       mr, mw, mtr, rst;

        n_vec = 0;
        n_err = 0;
        base_tbl = '{ADD_C, SLL_C, SLT_C, SLTU_C, XOR_C, SRL_C, OR_C, AND_C};

        reset = 1'b1; Funct7 = '0; Funct3 = '0;
        MemRead = 1'b0; MemWrite = 1'b0; MemToReg = 1'b0; ALUSrc = '0;

        // Reset wins over a SUB decode, then SUB appears one edge after release.
        apply("rst0", 1'b1, 7'h20, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        apply("rst1", 1'b1, 7'h20, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("rst.op_const", 32'(ALUOp), 32'(ADD_C));
        apply("rel_sub", 1'b0, 7'h20, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("rel_sub.op_const", 32'(ALUOp), 32'(SUB_C));

        // R-type ADD then SUB, and the full funct3 sweep.
        apply("r_add", 1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        apply("r_sub", 1'b0, 7'h20, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 1; i < 8; i++) begin
            apply($sformatf("r_f3_%0d", i), 1'b0, 7'h00, 3'(i), 1'b0, 1'b0, 1'b0, 2'd0);
        end
        apply("r_sra", 1'b0, 7'h20, 3'd5, 1'b0, 1'b0, 1'b0, 2'd0);

        // I-type: never SUB; funct7[5] selects SRA.
        apply("i_add", 1'b0, 7'h20, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1);
        apply("i_sra", 1'b0, 7'h20, 3'd5, 1'b0, 1'b0, 1'b0, 2'd1);
        apply("i_srl", 1'b0, 7'h00, 3'd5, 1'b0, 1'b0, 1'b0, 2'd1);
        apply("i_slt", 1'b0, 7'h00, 3'd2, 1'b0, 1'b0, 1'b0, 2'd1);

        // Memory qualifiers and the AUIPC/LUI classes.
        apply("mem_rd", 1'b0, 7'h00, 3'd7, 1'b1, 1'b0, 1'b0, 2'd0);
        apply("mem_wr", 1'b0, 7'h00, 3'd7, 1'b0, 1'b1, 1'b0, 2'd0);
        apply("mem_tr", 1'b0, 7'h00, 3'd2, 1'b0, 1'b0, 1'b1, 2'd0);
        apply("auipc", 1'b0, 7'h00, 3'd7, 1'b0, 1'b0, 1'b0, 2'd2);
        apply("lui", 1'b0, 7'h00, 3'd7, 1'b0, 1'b0, 1'b0, 2'd3);

        // Illegal R-type forms, then back to a legal ADD.
        apply("ill_mul", 1'b0, 7'h01, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        apply("ill_alt_or", 1'b0, 7'h20, 3'd6, 1'b0, 1'b0, 1'b0, 2'd0);
        apply("ill_alt_slt", 1'b0, 7'h20, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        apply("legal_add", 1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Randomized vectors biased toward the interesting funct7 patterns.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            f3  = 3'($urandom);
            src = 2'($urandom);
            mr  = ($urandom_range(0, 7) == 0);
            mw  = ($urandom_range(0, 7) == 0);
            mtr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 15) == 0);
            apply("rand", rst, f7, f3, mr, mw, mtr, src);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_controller.md
Name: alu_controller

Overview:
- Decodes RISC-V funct7/funct3 and main-control qualifiers into a 4-bit ALU operation code plus an operand-negate request.
- Sits between the main control decoder and the ALU in the single-cycle datapath.
- Outputs are registered: one-cycle latency, synchronous active-high reset.

Parameters:
- OP_W, 4, width of ALUOp (fixed encoding below; not meant to change)

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- Funct7  input  7  instruction bits [31:25]
- Funct3  input  3  instruction bits [14:12]
- MemRead  input  1  load instruction
- MemWrite  input  1  store instruction
- MemToReg  input  1  writeback-from-memory select
- ALUSrc  input  2  operand class: 00 reg/reg (R-type), 01 reg/imm (I-type), 10 PC+imm (AUIPC), 11 imm pass (LUI)
- ALUOp  output  4  registered ALU operation code
- ALUControlNegate  output  1  registered request for the ALU to use inverted B plus carry-in (compare path)

Behaviour:
- ALUOp encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, SLTU 1001, PASSB 1010; 1011-1111 never produced.
- Reset (reset=1 at rising edge): ALUOp<=0010 (ADD), ALUControlNegate<=0; reset has priority over decode.
- Otherwise, on each rising edge, register the combinational decode of the current inputs. Change at the input is visible after the next edge.
- Decode priority, highest first:
  1. MemRead|MemWrite|MemToReg=1: ADD, negate 0, regardless of Funct*/ALUSrc.
  2. ALUSrc=10: ADD, negate 0.
  3. ALUSrc=11: PASSB, negate 0.
  4. ALUSrc=00 (R-type), by Funct3:
     - 000: ADD if Funct7=0000000; SUB if Funct7=0100000
     - 001: SLL
     - 010: SLT
     - 011: SLTU
     - 100: XOR
     - 101: SRL if Funct7=0000000; SRA if Funct7=0100000
     - 110: OR
     - 111: AND
  5. ALUSrc=01 (I-type), by Funct3:
     - 000: ADD (Funct7 ignored; never SUB)
     - 001: SLL
     - 010: SLT
     - 011: SLTU
     - 100: XOR
     - 101: SRL if Funct7[5]=0, else SRA
     - 110: OR
     - 111: AND
- ALUControlNegate=1 only when the selected op is SLT or SLTU. It is 0 for SUB, since SUB's own code implies subtraction.
- Illegal R-type:
  - Condition: Funct7 not 0000000/0100000, or Funct7=0100000 with Funct3 not 000/101.
  - Decodes to ADD, negate 0. This includes M-extension Funct7=0000001.
- No internal state beyond the two output registers; X-free outputs after reset.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_DET_EN.
- Defined: adds output port IllegalOp (1 bit), registered with the same one-cycle latency.
  - Reset value 0.
  - Set to 1 for the illegal R-type conditions above; 0 for all other inputs.
- Undefined: port absent; decode and outputs otherwise identical.

Test Plan:
- Reset=1 for 2 edges with Funct7=0100000, Funct3=000, ALUSrc=00 -> ALUOp=0010, negate=0; after release plus one edge -> ALUOp=0110.
- R-type, Funct7=0000000, Funct3=000, mem flags 0, ALUSrc=00 -> after one edge ALUOp=0010, negate=0. Then Funct7=0100000 -> next edge ALUOp=0110, negate=0.
- Sweep R-type Funct3 001..111 with Funct7=0000000 -> 0100, 0111/neg1, 1001/neg1, 0011, 0101, 0001, 0000. Funct3=101 with Funct7=0100000 -> 1000.
- I-type ALUSrc=01, Funct7=0100000, Funct3=000 -> 0010 (not SUB). Funct3=101, Funct7=0100000 -> 1000.
- MemRead=1 (then MemWrite=1) with Funct3=111, ALUSrc=00 -> 0010, negate 0. ALUSrc=10 -> 0010. ALUSrc=11 -> 1010.
- Funct7=0000001, Funct3=000, ALUSrc=00 -> ALUOp=0010, negate 0; with ALU_CTRL_ILLEGAL_DET_EN, IllegalOp=1 one edge later, back to 0 for a legal ADD.
